// File: rtl/request_encoder4to2_if.sv
// Request/grant bundle between the requesters, the encoder and its consumer.
//   req     : level requests, bit i = requester i
//   ready   : consumer accepts the current address this cycle
//   valid   : address/onehot/multi hold a grant
//   address : encoded index of the granted requester
//   onehot  : one-hot copy of address while valid, else 0
//   multi   : more than one request was set when the grant was captured
// master drives req/ready (requesters + consumer side), slave is the encoder.
interface request_encoder4to2_if;
  logic [3:0] req;
  logic       ready;
  logic       valid;
  logic [1:0] address;
  logic [3:0] onehot;
  logic       multi;

  modport master (output req, ready, input valid, address, onehot, multi);
  modport slave  (input req, ready, output valid, address, onehot, multi);
endinterface

// File: rtl/request_encoder4to2.sv
// Registered 4-to-2 request encoder with valid/ready handshake.
// Turns up to four level requests into a 2-bit address for a single consumer,
// serving requesters one per transfer. All outputs are registered.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : request_encoder4to2_if.slave (req, ready in; valid, address,
//           onehot, multi out)
// Parameter:
//   RESET_PTR : round-robin pointer after reset (index searched first)
// Build option:
//   REQUEST_ENCODER_RR_EN defined   -> round-robin selection from the pointer
//   REQUEST_ENCODER_RR_EN undefined -> fixed priority, index 0 highest
module request_encoder4to2 #(
  parameter logic [1:0] RESET_PTR = 2'd0
) (
  input  logic                   clk,
  input  logic                   reset,
  request_encoder4to2_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic       valid_q;
  logic [1:0] address_q;
  logic [3:0] onehot_q;
  logic       multi_q;

  logic [1:0] base;
  logic [1:0] pick;
  logic       many;

  // First set bit of r searching p, p+1, ... wrapping 3->0. Scanning the
  // offsets from farthest to nearest lets the nearest hit overwrite.
  function automatic logic [1:0] sel(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    sel = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) sel = idx;
    end
  endfunction

`ifdef REQUEST_ENCODER_RR_EN
  logic [1:0] ptr;

  // On a transfer the next search starts just past the current grant, which
  // is the value ptr is about to take; in IDLE the stored pointer is used.
  assign base = (state == GRANT) ? address_q + 2'd1 : ptr;
`else
  // Fixed priority always searches from index 0. RESET_PTR has no effect in
  // this build; folding it to zero keeps the parameter referenced.
  localparam logic [1:0] FIXED_BASE = RESET_PTR & 2'b00;
  assign base = FIXED_BASE;
`endif

  assign pick = sel(bus.req, base);
  // popcount > 1 <=> clearing the lowest set bit leaves something behind
  assign many = |(bus.req & (bus.req - 4'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      address_q <= 2'b00;
      onehot_q  <= 4'b0000;
      multi_q   <= 1'b0;
`ifdef REQUEST_ENCODER_RR_EN
      ptr       <= RESET_PTR;
`endif
    end else begin
      case (state)
        IDLE: begin
          // ready is ignored here; only a request starts a grant
          if (|bus.req) begin
            state     <= GRANT;
            valid_q   <= 1'b1;
            address_q <= pick;
            onehot_q  <= 4'b0001 << pick;
            multi_q   <= many;
          end
        end
        GRANT: begin
          // Without ready everything holds; req changes are not looked at,
          // so a grant is never withdrawn.
          if (bus.ready) begin
`ifdef REQUEST_ENCODER_RR_EN
            ptr <= address_q + 2'd1;
`endif
            if (|bus.req) begin
              address_q <= pick;
              onehot_q  <= 4'b0001 << pick;
              multi_q   <= many;
            end else begin
              state     <= IDLE;
              valid_q   <= 1'b0;
              address_q <= 2'b00;
              onehot_q  <= 4'b0000;
              multi_q   <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.valid   = valid_q;
  assign bus.address = address_q;
  assign bus.onehot  = onehot_q;
  assign bus.multi   = multi_q;

endmodule

// File: tb/tb_request_encoder4to2.sv
module tb_request_encoder4to2;

`ifdef REQUEST_ENCODER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  request_encoder4to2_if bus();
  request_encoder4to2_if bus2();

  request_encoder4to2 #(.RESET_PTR(2'd0)) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  request_encoder4to2 #(.RESET_PTR(2'd2)) u_dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2)
  );

  typedef struct {
    bit         rst;
    logic [3:0] req;
    bit         rdy;
    bit         v;
    logic [1:0] a;
    logic [3:0] oh;
    bit         m;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Expected onehot is written out from the expected address here.
  task automatic add(input bit rst, input logic [3:0] req, input bit rdy,
                     input bit v, input logic [1:0] a, input bit m);
    vec_t t;
    t.rst = rst; t.req = req; t.rdy = rdy; t.v = v; t.a = a; t.m = m;
    case ({v, a})
      3'b100:  t.oh = 4'b0001;
      3'b101:  t.oh = 4'b0010;
      3'b110:  t.oh = 4'b0100;
      3'b111:  t.oh = 4'b1000;
      default: t.oh = 4'b0000;
    endcase
    vecs.push_back(t);
  endtask

  task automatic chk_out(input string tag, input bit v, input logic [1:0] a,
                         input logic [3:0] oh, input bit m);
    chk({tag, ".valid"},   {3'b0, bus.valid},   {3'b0, v});
    chk({tag, ".address"}, {2'b0, bus.address}, {2'b0, a});
    chk({tag, ".onehot"},  bus.onehot,          oh);
    chk({tag, ".multi"},   {3'b0, bus.multi},   {3'b0, m});
  endtask

  initial begin
    bus.req = 4'b0;  bus.ready = 1'b0;
    bus2.req = 4'b0; bus2.ready = 1'b0;

    // reset held with all requests up
    add(1, 4'b1111, 0, 0, 0, 0);
    // back-to-back, RESET_PTR=0
    add(0, 4'b1111, 1, 1, 0,          1);
    add(0, 4'b1111, 1, 1, RR ? 1 : 0, 1);
    add(0, 4'b1111, 1, 1, RR ? 2 : 0, 1);
    add(0, 4'b1111, 1, 1, RR ? 3 : 0, 1);
    add(0, 4'b1111, 1, 1, 0,          1);
    add(0, 4'b1111, 1, 1, RR ? 1 : 0, 1);
    add(0, 4'b0000, 1, 0, 0, 0);               // RR pointer now 2
    // stall: granted bit drops while ready=0, grant holds
    add(0, 4'b0110, 0, 1, RR ? 2 : 1, 1);
    add(0, 4'b0001, 0, 1, RR ? 2 : 1, 1);
    add(0, 4'b0001, 0, 1, RR ? 2 : 1, 1);
    add(0, 4'b0001, 0, 1, RR ? 2 : 1, 1);
    add(0, 4'b0001, 1, 1, 0, 0);
    add(0, 4'b0000, 1, 0, 0, 0);               // RR pointer now 1, ready in IDLE
    // wrap 3 -> 0
    add(0, 4'b1001, 0, 1, RR ? 3 : 0, 1);
    add(0, 4'b1001, 1, 1, 0,          1);
    add(0, 4'b1001, 1, 1, RR ? 3 : 0, 1);
    add(0, 4'b0000, 1, 0, 0, 0);
    // reset, then a single request
    add(1, 4'b1111, 1, 0, 0, 0);
    add(0, 4'b0100, 1, 1, 2, 0);
    add(0, 4'b0000, 1, 0, 0, 0);
    // lone requester keeps winning
    add(0, 4'b0100, 1, 1, 2, 0);
    add(0, 4'b0100, 1, 1, 2, 0);
    add(0, 4'b0000, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset     = vecs[i].rst;
      bus.req   = vecs[i].req;
      bus.ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].a, vecs[i].oh, vecs[i].m);
    end

    // asynchronous reset in the middle of a grant
    @(negedge clk);
    reset = 1'b0; bus.req = 4'b1111; bus.ready = 1'b0;
    @(posedge clk); #1;
    chk("async.pre_valid", {3'b0, bus.valid}, 4'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_out("async.immediate", 0, 0, 4'b0000, 0);
    @(posedge clk); #1;
    chk_out("async.held", 0, 0, 4'b0000, 0);

    // RESET_PTR=2 instance: grant at 1, pulse reset, then first grant
    @(negedge clk);
    reset = 1'b0; bus.req = 4'b0000;
    bus2.req = 4'b0010; bus2.ready = 1'b0;
    @(posedge clk); #1;
    chk("rp2.grant_addr",  {2'b0, bus2.address}, 4'd1);
    chk("rp2.grant_valid", {3'b0, bus2.valid},   4'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rp2.reset_valid", {3'b0, bus2.valid}, 4'd0);
    @(negedge clk);
    reset = 1'b0; bus2.req = 4'b0111;
    @(posedge clk); #1;
    chk("rp2.first_valid",  {3'b0, bus2.valid},   4'd1);
    chk("rp2.first_addr",   {2'b0, bus2.address}, RR ? 4'd2 : 4'd0);
    chk("rp2.first_onehot", bus2.onehot,          RR ? 4'b0100 : 4'b0001);
    chk("rp2.first_multi",  {3'b0, bus2.multi},   4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/request_encoder4to2.md
# request_encoder4to2

Registered 4-to-2 request encoder. It turns up to four level-sensitive request lines into a 2-bit address, the inverse of the 2-to-4 address decoder. The address is presented with a valid/ready handshake so a single downstream consumer (bus mux select, register-file port) services requesters one at a time. Arbitration among simultaneous requests is round-robin, or fixed priority when the round-robin feature is compiled out.

## Interface
- RESET_PTR, default 2'd0, round-robin pointer value after reset (index searched first).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  level requests; bit i = requester i.
- ready  input  1  consumer accepts the current address this cycle.
- valid  output  1  address/onehot/multi hold a grant.
- address  output  2  encoded index of the granted requester.
- onehot  output  4  one-hot copy of address while valid, else 4'b0000.
- multi  output  1  more than one req bit was set when this grant was captured.

## Operation
- Two states: IDLE (valid=0) and GRANT (valid=1).
- All outputs are registered. There is no combinational path from req or ready to any output.
- Selection function sel(req, ptr): the first set bit of req searching ptr, ptr+1, … mod 4, wrapping 3→0.
- IDLE:
  - If req≠0: go to GRANT. Load address=sel(req, pointer), onehot=1<<address, multi=(popcount(req)>1).
  - Otherwise stay in IDLE with address, onehot and multi at 0.
- GRANT, ready=0 (stall):
  - address, onehot, multi and valid hold.
  - Changes on req are ignored, including the granted bit dropping. A grant is never withdrawn.
- GRANT, ready=1 (transfer):
  - pointer ← address+1 mod 4.
  - If req≠0: stay in GRANT and load the new grant sel(req, address+1) in the same edge, so transfers run back-to-back.
  - If req=0: go to IDLE and clear valid, onehot and multi.
- The granted requester's bit, if still set, is searched last. It wins again only if it is the only request.
- ready while in IDLE is ignored.
- Reset: valid=0, address=2'b00, onehot=4'b0000, multi=0, pointer=RESET_PTR, state IDLE.

## Timing
- Latency: req asserted in cycle N (sampled at the edge ending N) gives valid=1 in cycle N+1.
- Throughput: one grant per cycle while ready=1 and req≠0.
- Handshake: a transfer occurs on any rising edge where valid=1 and ready=1. The new grant, or valid=0, is visible after that edge.
- Reset is asynchronous. Outputs go to their reset values immediately on assertion, without waiting for clk.
- Reset may be asserted mid-GRANT; the pending grant is lost and no transfer is recorded.
- Deassertion: the first capture happens at the first rising edge after reset falls.
- Pointer arithmetic is 2-bit modulo. address=3 followed by a transfer gives pointer=0.

## Configuration
- Macro: REQUEST_ENCODER_RR_EN.
- Defined: round-robin selection as described above, using the pointer.
- Not defined:
  - Fixed priority. sel(req) returns the lowest set index, with index 0 highest priority.
  - The pointer register and RESET_PTR are unused and the pointer may be optimised away.
  - Handshake, latency and the multi flag are unchanged.

## Test plan
- Reset: assert reset asynchronously mid-cycle with req=4'b1111 → valid=0, address=0, onehot=0000, multi=0 immediately, and held while reset is high.
- Single request: from IDLE apply req=0100 for one cycle, ready=1 → next cycle valid=1, address=2, onehot=0100, multi=0; the cycle after that, valid=0.
- Back-to-back: req=1111 held, ready=1, RESET_PTR=0.
  - RR on: address sequence 0,1,2,3,0,1 on consecutive cycles, multi=1 throughout.
  - RR off: address=0 every cycle.
- Stall: grant address=2 from req=0110, then ready=0 for 3 cycles while req changes to 0001 → address=2, onehot=0100, multi=1 hold all 3 cycles. Raising ready gives address=0 on the next cycle.
- Wrap: RR on, grant address=3 with req=1001 → ready=1 gives address=0 next cycle; a further ready=1 with req=1001 gives address=3.
- Reset mid-grant: RESET_PTR=2, grant at address=1, pulse reset, then req=0111 → first grant after reset is address=2 (RR on) or address=0 (RR off).
